// File: rtl/kf_pkg.sv
// Shared constants for the Kalman-filter sequencer and its datapath stages:
// state encoding, stage indices and small state-decode helpers.
package kf_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_L0   = 4'd1,
    ST_W0   = 4'd2,
    ST_L1   = 4'd3,
    ST_W1   = 4'd4,
    ST_L2   = 4'd5,
    ST_W2   = 4'd6,
    ST_L3   = 4'd7,
    ST_W3   = 4'd8,
    ST_FIN  = 4'd9,
    ST_ERR  = 4'd10
  } kf_state_e;

  localparam logic [1:0] STG_PS = 2'd0;
  localparam logic [1:0] STG_PC = 2'd1;
  localparam logic [1:0] STG_KG = 2'd2;
  localparam logic [1:0] STG_UP = 2'd3;

  function automatic logic is_wait(input kf_state_e s);
    return (s == ST_W0) || (s == ST_W1) || (s == ST_W2) || (s == ST_W3);
  endfunction

  // Stage index owning a launch or wait state; other states map to stage 0.
  function automatic logic [1:0] stage_of(input kf_state_e s);
    logic [1:0] idx;
    idx = STG_PS;
    case (s)
      ST_L1, ST_W1: idx = STG_PC;
      ST_L2, ST_W2: idx = STG_KG;
      ST_L3, ST_W3: idx = STG_UP;
      default:      idx = STG_PS;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/kf_stage_wdt.sv
// Stage wait watchdog: down-counter loaded while idle (clr), expires on the
// TMO_CYC-th consecutive enabled cycle.
module kf_stage_wdt #(
  parameter int TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = 10;
  localparam logic [CW-1:0] TC_LOAD = CW'(TMO_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= TC_LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/kf_iter_seq.sv
// Kalman iteration sequencer: launches the four stages in order and counts
// completed iterations. Optional stage watchdog under KF_SEQ_WDT_EN.
//
// state | meaning
// IDLE  | waiting for go
// Li    | stg_start[i] pulse (i = 0..3)
// Wi    | waiting for stg_done[i]
// FIN   | iteration complete, iter_done high, iter_cnt bumps
// ERR   | stage wait timed out, err latched
module kf_iter_seq
  import kf_pkg::*;
#(
  parameter int TMO_CYC = 64,
  parameter int ITER_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go_valid,
  output logic              go_ready,
  input  logic              abort,
  output logic [3:0]        stg_start,
  input  logic [3:0]        stg_done,
  output logic              busy,
  output logic              iter_done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              err,
  output logic [1:0]        err_stage
);

  kf_state_e state, state_nxt;
  logic       rdy_q;
  logic       go_acc;
  logic       in_wait;
  logic [1:0] cur_stg;
  logic       stg_hit;
  logic       tmo;

  assign in_wait = is_wait(state);
  assign cur_stg = stage_of(state);
  assign stg_hit = in_wait && stg_done[cur_stg];

`ifdef KF_SEQ_WDT_EN
  logic expired;

  kf_stage_wdt #(.TMO_CYC(TMO_CYC)) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (expired)
  );

  // A done arriving in the expiry cycle still counts as success.
  assign tmo = expired && !stg_hit;
`else
  assign tmo = 1'b0;
`endif

  // Holds go_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  assign go_ready  = rdy_q && (state == ST_IDLE);
  assign go_acc    = go_valid && go_ready && !abort;
  assign busy      = (state != ST_IDLE);
  assign iter_done = (state == ST_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (go_acc) state_nxt = ST_L0;
        ST_L0:   state_nxt = ST_W0;
        ST_L1:   state_nxt = ST_W1;
        ST_L2:   state_nxt = ST_W2;
        ST_L3:   state_nxt = ST_W3;
        ST_W0: begin
          if (stg_hit)  state_nxt = ST_L1;
          else if (tmo) state_nxt = ST_ERR;
        end
        ST_W1: begin
          if (stg_hit)  state_nxt = ST_L2;
          else if (tmo) state_nxt = ST_ERR;
        end
        ST_W2: begin
          if (stg_hit)  state_nxt = ST_L3;
          else if (tmo) state_nxt = ST_ERR;
        end
        ST_W3: begin
          if (stg_hit)  state_nxt = ST_FIN;
          else if (tmo) state_nxt = ST_ERR;
        end
        ST_FIN:  state_nxt = ST_IDLE;
        ST_ERR:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stg_start = 4'b0000;
    case (state)
      ST_L0:   stg_start[STG_PS] = 1'b1;
      ST_L1:   stg_start[STG_PC] = 1'b1;
      ST_L2:   stg_start[STG_KG] = 1'b1;
      ST_L3:   stg_start[STG_UP] = 1'b1;
      default: stg_start = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 iter_cnt <= '0;
    else if (state == ST_FIN)   iter_cnt <= iter_cnt + 1'b1;
  end

`ifdef KF_SEQ_WDT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_stage <= 2'd0;
    end else if (go_acc) begin
      err       <= 1'b0;
    end else if (state_nxt == ST_ERR) begin
      err       <= 1'b1;
      err_stage <= cur_stg;
    end
  end
`else
  assign err       = 1'b0;
  assign err_stage = 2'd0;
`endif

endmodule

// File: tb/tb_kf_iter_seq.sv
// Self-checking bench for kf_iter_seq: directed vector table, multi-cycle
// corner sequences and a randomized run against a stage-level model.
module tb_kf_iter_seq;

  localparam int TMO     = 16;
  localparam int IW      = 2;
  localparam int CNT_MOD = 1 << IW;
`ifdef KF_SEQ_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go_valid;
  logic          go_ready;
  logic          abort;
  logic [3:0]    stg_start;
  logic [3:0]    stg_done;
  logic          busy;
  logic          iter_done;
  logic [IW-1:0] iter_cnt;
  logic          err;
  logic [1:0]    err_stage;

  int n_chk  = 0;
  int n_fail = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  kf_iter_seq #(.TMO_CYC(TMO), .ITER_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go_valid  (go_valid),
    .go_ready  (go_ready),
    .abort     (abort),
    .stg_start (stg_start),
    .stg_done  (stg_done),
    .busy      (busy),
    .iter_done (iter_done),
    .iter_cnt  (iter_cnt),
    .err       (err),
    .err_stage (err_stage)
  );

  // dly[i]: extra wait cycles before stg_done[i]; abort_stg: stage whose
  // first wait cycle carries abort + done (-1 = none).
  typedef struct {
    logic [3:0][7:0] dly;
    int              abort_stg;
    int              exp_cycles;
    int              exp_done;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int due[4];
    int abort_due;
    int nlaunch;
    int ndone;
    int cyc;
    bit seen_ready;
    for (int i = 0; i < 4; i++) due[i] = -1;
    abort_due  = -1;
    nlaunch    = 0;
    ndone      = 0;
    seen_ready = 1'b0;
    chk({tag, " ready"}, 32'(go_ready), 32'd1);
    go_valid = 1'b1;
    tick();
    go_valid = 1'b0;
    cyc = 1;
    while (cyc < 400 && !seen_ready) begin
      stg_done = 4'b0000;
      abort    = 1'b0;
      if (stg_start != 4'b0000) begin
        chk({tag, " start order"}, 32'(stg_start), 32'd1 << nlaunch);
        if (nlaunch < 4) begin
          if (v.abort_stg == nlaunch) abort_due = cyc + 1;
          else due[nlaunch] = cyc + 1 + int'(v.dly[nlaunch]);
        end
        nlaunch++;
      end
      for (int i = 0; i < 4; i++) if (due[i] == cyc) stg_done[i] = 1'b1;
      if (cyc == abort_due) begin
        abort = 1'b1;
        stg_done[v.abort_stg] = 1'b1;
      end
      if (iter_done) ndone++;
      if (go_ready) seen_ready = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    stg_done = 4'b0000;
    abort    = 1'b0;
    if (v.exp_done != 0) m_cnt = (m_cnt + 1) % CNT_MOD;
    chk({tag, " cycles"}, 32'(cyc), 32'(v.exp_cycles));
    chk({tag, " iter_done count"}, 32'(ndone), 32'(v.exp_done));
    chk({tag, " launches"}, 32'(nlaunch), (v.abort_stg < 0) ? 32'd4 : 32'(v.abort_stg + 1));
    chk({tag, " iter_cnt"}, 32'(iter_cnt), 32'(m_cnt));
  endtask

  vec_t vecs[6];
  int   wrap_exp[5];

  initial begin
    logic [11:0] exp_o;
    logic [11:0] act_o;
    int   mode, stg, wt, m_err, m_es;
    bit   gv, ab;
    logic [3:0] sd;
    localparam int M_IDLE = 0, M_LAUNCH = 1, M_WAIT = 2, M_FIN = 3, M_ERR = 4;

    vecs[0] = '{dly: {8'd0, 8'd0, 8'd0, 8'd0}, abort_stg: -1, exp_cycles: 10, exp_done: 1};
    vecs[1] = '{dly: {8'd7, 8'd7, 8'd7, 8'd7}, abort_stg: -1, exp_cycles: 38, exp_done: 1};
    vecs[2] = '{dly: {8'd4, 8'd3, 8'd2, 8'd1}, abort_stg: -1, exp_cycles: 20, exp_done: 1};
    vecs[3] = '{dly: {8'd0, 8'd0, 8'd0, 8'd0}, abort_stg: 2,  exp_cycles: 7,  exp_done: 0};
    vecs[4] = '{dly: {8'd0, 8'd0, 8'd0, 8'd0}, abort_stg: 0,  exp_cycles: 3,  exp_done: 0};
    vecs[5] = '{dly: {8'd1, 8'd5, 8'd0, 8'd3}, abort_stg: -1, exp_cycles: 19, exp_done: 1};
    wrap_exp = '{1, 2, 3, 0, 1};

    rst_n = 1'b0; go_valid = 1'b0; abort = 1'b0; stg_done = 4'b0000;
    repeat (2) tick();
    chk("reset outputs", {go_ready, busy, iter_done, stg_start, iter_cnt, err, err_stage}, 12'h000);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("go_ready before first edge", 32'(go_ready), 32'd0);
    tick();
    chk("go_ready after first edge", 32'(go_ready), 32'd1);
    chk("busy idle", 32'(busy), 32'd0);

    for (int k = 0; k < 5; k++) begin
      run_vec(vecs[0], "wrap");
      chk("wrap sequence", 32'(iter_cnt), 32'(wrap_exp[k]));
    end

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // stray dones in W0 must be ignored
    go_valid = 1'b1; tick(); go_valid = 1'b0;
    chk("stray L0 start", 32'(stg_start), 32'h1);
    tick();
    stg_done = 4'b1110; tick(); stg_done = 4'b0000;
    chk("stray held start", 32'(stg_start), 32'h0);
    chk("stray held busy", 32'(busy), 32'd1);
    stg_done = 4'b0001; tick(); stg_done = 4'b0000;
    chk("stray L1 start", 32'(stg_start), 32'h2);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort in L1 ready", 32'(go_ready), 32'd1);
    chk("abort keeps iter_cnt", 32'(iter_cnt), 32'(m_cnt));

    // abort in IDLE blocks the go
    go_valid = 1'b1; abort = 1'b1; tick(); go_valid = 1'b0; abort = 1'b0;
    chk("idle abort busy", 32'(busy), 32'd0);
    chk("idle abort start", 32'(stg_start), 32'h0);

    // stage 1 done withheld
    go_valid = 1'b1; tick(); go_valid = 1'b0;
    tick();
    stg_done = 4'b0001; tick(); stg_done = 4'b0000;
    tick();
    chk("wdt in W1", {busy, stg_start}, 5'b10000);
`ifdef KF_SEQ_WDT_EN
    repeat (15) tick();
    chk("wdt before expiry err", 32'(err), 32'd0);
    chk("wdt before expiry busy", 32'(busy), 32'd1);
    tick();
    chk("wdt err", 32'(err), 32'd1);
    chk("wdt err_stage", 32'(err_stage), 32'd1);
    tick();
    chk("wdt back to idle", 32'(go_ready), 32'd1);
    chk("wdt err sticky", 32'(err), 32'd1);
    go_valid = 1'b1; tick(); go_valid = 1'b0;
    chk("go clears err", 32'(err), 32'd0);
    abort = 1'b1; tick(); abort = 1'b0;
`else
    repeat (1000) tick();
    chk("no wdt still waiting", {busy, go_ready, stg_start}, 6'b100000);
    chk("no wdt err", 32'(err), 32'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("no wdt abort ready", 32'(go_ready), 32'd1);
`endif

    // async reset while in W2
    go_valid = 1'b1; tick(); go_valid = 1'b0;
    tick();
    stg_done = 4'b0001; tick(); stg_done = 4'b0000;
    tick();
    stg_done = 4'b0010; tick(); stg_done = 4'b0000;
    tick();
    chk("in W2 before reset", {busy, stg_start}, 5'b10000);
    #3 rst_n = 1'b0;
    #1 chk("async reset outputs", {go_ready, busy, iter_done, stg_start, iter_cnt, err, err_stage}, 12'h000);
    m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post reset no launch", {busy, stg_start}, 5'b00000);
    end

    // randomized run against the stage-level model
    mode = M_IDLE; stg = 0; wt = 0; m_err = 0; m_es = 0;
    for (int c = 0; c < 3000; c++) begin
      exp_o = {mode == M_IDLE, mode != M_IDLE, mode == M_FIN,
               (mode == M_LAUNCH) ? (4'b0001 << stg) : 4'b0000,
               IW'(m_cnt), m_err[0], 2'(m_es)};
      act_o = {go_ready, busy, iter_done, stg_start, iter_cnt, err, err_stage};
      chk($sformatf("random cycle %0d", c), 32'(act_o), 32'(exp_o));
      gv = ($urandom_range(0, 1) == 1);
      ab = (mode != M_FIN) && ($urandom_range(0, 29) == 0);
      sd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      go_valid = gv; abort = ab; stg_done = sd;
      case (mode)
        M_IDLE: if (gv && !ab) begin mode = M_LAUNCH; stg = 0; m_err = 0; end
        M_FIN: begin m_cnt = (m_cnt + 1) % CNT_MOD; mode = M_IDLE; end
        default: begin
          if (ab) mode = M_IDLE;
          else if (mode == M_LAUNCH) begin mode = M_WAIT; wt = 0; end
          else if (mode == M_WAIT) begin
            if (sd[stg]) begin
              if (stg == 3) mode = M_FIN;
              else begin stg++; mode = M_LAUNCH; end
            end else if (WDT && wt == TMO - 1) begin
              mode = M_ERR; m_err = 1; m_es = stg;
            end else wt++;
          end else mode = M_IDLE;
        end
      endcase
      tick();
    end
    go_valid = 1'b0; abort = 1'b0; stg_done = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
